mem_ctrl: RTL and testbench

- Arbitrates the single byte-wide RAM/IO port between instruction fetch (IF) and the load/store buffer (LSB).
- Serialises each 1/2/4-byte request into consecutive byte transactions and assembles read data little-endian.
- Returns a one-cycle done pulse to the granted requester.
- Sits between the IF unit and the LSB on one side and the top-level RAM/IO bus on the other.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_ctrl_if.sv | 37 +++
 rtl/mem_ctrl.sv | 118 +++++++++++
 tb/tb_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and widths for the byte-serial memory controller.
// State names, bus widths, IO space marker and a byte-lane selector.
package mem_ctrl_pkg;

  localparam int ADDR_WID   = 32;
  localparam int DATA_WID   = 32;
  localparam int ST_LEN_WID = 3;

  localparam logic [1:0] MC_IO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  function automatic logic [7:0] byte_sel(input logic [DATA_WID-1:0] w,
                                          input logic [ST_LEN_WID-1:0] k);
    return w[{k[1:0], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester (IF/LSB) and byte-wide RAM/IO bus bundle around mem_ctrl.
// slave is the controller's view; master is the surrounding chip's view.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              rdy;
  logic              rollback;
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  logic              lsb_valid;
  logic              lsb_is_store;
  logic [ADDR_W-1:0] lsb_addr;
  logic [2:0]        lsb_len;
  logic [31:0]       lsb_wdata;
  logic              lsb_done;
  logic [31:0]       lsb_rdata;
  logic              io_buffer_full;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  rdy, rollback, if_valid, if_addr, lsb_valid, lsb_is_store,
           lsb_addr, lsb_len, lsb_wdata, io_buffer_full, mem_din,
    output if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, rollback, if_valid, if_addr, lsb_valid, lsb_is_store,
           lsb_addr, lsb_len, lsb_wdata, io_buffer_full, mem_din,
    input  if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF and LSB onto one byte-wide RAM/IO port, LSB first; reads done at C+len+2, writes at C+len+1.
// Requesters hold valid until their done pulse; rdy low freezes everything, full IO buffer stalls IO writes.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_WID,
  parameter logic [1:0] IO_PREFIX = MC_IO_PREFIX,
  parameter int         IF_LEN    = 4
) (
  input  logic     clk,
  input  logic     rst,
  mem_ctrl_if.slave bus
);

  mc_state_e             r_state, w_next;
  logic                  r_owner_lsb;
  logic                  r_store;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     r_last_a;
  logic [7:0]            r_last_d;
  logic [ST_LEN_WID-1:0] r_len;
  logic [ST_LEN_WID-1:0] r_k;
  logic [DATA_WID-1:0]   r_wdata;
  logic [DATA_WID-1:0]   r_buf;

  logic                  w_grant_lsb, w_grant_if;
  logic                  w_stall, w_kill, w_drive, w_done;
  logic [ST_LEN_WID-1:0] w_km1;
  logic [ADDR_W-1:0]     w_mem_a;
  logic [7:0]            w_mem_dout;

  always_comb begin
    w_next      = r_state;
    w_grant_lsb = 1'b0;
    w_grant_if  = 1'b0;
    w_stall     = (r_state == MC_WRITE) && bus.io_buffer_full &&
                  (r_addr[17:16] == IO_PREFIX);
    // Stores are already committed to memory, so only loads/fetches are flushed.
    w_kill      = bus.rollback && !r_store;
    w_km1       = r_k - ST_LEN_WID'(1);
    w_drive     = (r_state == MC_WRITE) || ((r_state == MC_READ) && (r_k != r_len));
    w_done      = bus.rdy && (r_state == MC_DONE) && !w_kill;
    w_mem_a     = w_drive ? (r_addr + ADDR_W'(r_k)) : r_last_a;
    w_mem_dout  = (r_state == MC_WRITE) ? byte_sel(r_wdata, r_k) : r_last_d;

    case (r_state)
      MC_IDLE: begin
        if (!bus.rollback) begin
          if (bus.lsb_valid) begin
            w_grant_lsb = 1'b1;
            w_next      = bus.lsb_is_store ? MC_WRITE : MC_READ;
          end else if (bus.if_valid) begin
            w_grant_if = 1'b1;
            w_next     = MC_READ;
          end
        end
      end
      MC_READ: begin
        if (w_kill)              w_next = MC_IDLE;
        else if (r_k == r_len)   w_next = MC_DONE;
      end
      MC_WRITE: begin
        if (!w_stall && (r_k == r_len - ST_LEN_WID'(1))) w_next = MC_DONE;
      end
      MC_DONE:  w_next = MC_IDLE;
      default:  w_next = MC_IDLE;
    endcase
  end

  assign bus.mem_a     = w_mem_a;
  assign bus.mem_dout  = w_mem_dout;
  assign bus.mem_wr    = bus.rdy && (r_state == MC_WRITE) && !w_stall;
  assign bus.if_done   = w_done && !r_owner_lsb;
  assign bus.lsb_done  = w_done && r_owner_lsb;
  assign bus.if_data   = r_buf;
  assign bus.lsb_rdata = r_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MC_IDLE;
      r_owner_lsb <= 1'b0;
      r_store     <= 1'b0;
      r_addr      <= '0;
      r_last_a    <= '0;
      r_last_d    <= '0;
      r_len       <= '0;
      r_k         <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
    end else if (bus.rdy) begin
      r_state <= w_next;

      if (w_drive) begin
        r_last_a <= w_mem_a;
        r_last_d <= w_mem_dout;
      end

      if (w_grant_lsb || w_grant_if) begin
        r_owner_lsb <= w_grant_lsb;
        r_store     <= w_grant_lsb && bus.lsb_is_store;
        r_addr      <= w_grant_lsb ? bus.lsb_addr : bus.if_addr;
        r_len       <= w_grant_lsb ? bus.lsb_len : ST_LEN_WID'(IF_LEN);
        r_wdata     <= w_grant_lsb ? bus.lsb_wdata : '0;
        r_k         <= '0;
        r_buf       <= '0;
      end

      // RAM answers one cycle late, so byte k-1 arrives while address k is out.
      if (r_state == MC_READ) begin
        if (r_k != '0)    r_buf[{w_km1[1:0], 3'b000} +: 8] <= bus.mem_din;
        if (r_k != r_len) r_k <= r_k + ST_LEN_WID'(1);
      end

      if ((r_state == MC_WRITE) && !w_stall) r_k <= r_k + ST_LEN_WID'(1);
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of LSB transfers plus hand-built arbitration, rollback, stall and freeze sequences.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) m ();

  mem_ctrl #(.ADDR_W(32), .IO_PREFIX(2'b11), .IF_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  // Synchronous byte RAM: read data is for the previous cycle's address; frozen with rdy.
  logic [7:0] ram [0:262143];
  always @(posedge clk) begin
    if (m.rdy) begin
      if (m.mem_wr) ram[m.mem_a[17:0]] <= m.mem_dout;
      m.mem_din <= ram[m.mem_a[17:0]];
    end
  end

  typedef struct {
    bit          is_if;
    bit          chk;
    logic [31:0] dat;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit          st;
    logic [31:0] a;
    logic [2:0]  len;
    logic [31:0] wd;
    logic [31:0] exp;
    int          off;
  } vec_t;
  vec_t vq[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic on_done(input bit is_if, input logic [31:0] act);
    sb_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_done", 32'(is_if), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("sb_owner", 32'(is_if), 32'(e.is_if));
      if (e.chk) chk("sb_data", act, e.dat);
    end
  endtask

  task automatic addv(input bit st, input logic [31:0] a, input logic [2:0] len,
                      input logic [31:0] wd, input logic [31:0] exp, input int off);
    vec_t v;
    v.st = st; v.a = a; v.len = len; v.wd = wd; v.exp = exp; v.off = off;
    vq.push_back(v);
  endtask

  task automatic run_lsb(input vec_t v);
    sb_t e;
    bit got;
    logic [31:0] ea;
    logic [31:0] ew;
    @(negedge clk);
    m.lsb_valid    = 1'b1;
    m.lsb_is_store = v.st;
    m.lsb_addr     = v.a;
    m.lsb_len      = v.len;
    m.lsb_wdata    = v.wd;
    e.is_if = 1'b0; e.chk = !v.st; e.dat = v.exp;
    sb.push_back(e);
    got = 1'b0;
    for (int off = 1; off <= 30 && !got; off++) begin
      @(negedge clk); #1;
      if (off <= int'(v.len)) begin
        ea = v.a + 32'(off - 1);
        chk("mem_a", m.mem_a, ea);
        chk("mem_wr", 32'(m.mem_wr), 32'(v.st));
        if (v.st) begin
          ew = (v.wd >> (8 * (off - 1))) & 32'hFF;
          chk("mem_dout", 32'(m.mem_dout), ew);
        end
      end
      if (m.lsb_done) begin
        got = 1'b1;
        chk("lsb_done_cycle", 32'(off), 32'(v.off));
        on_done(1'b0, m.lsb_rdata);
        m.lsb_valid = 1'b0;
      end
    end
    if (!got) begin
      chk("lsb_done_timeout", 32'd0, 32'd1);
      void'(sb.pop_back());
      m.lsb_valid = 1'b0;
    end else begin
      @(negedge clk); #1;
      chk("lsb_done_one_cycle", 32'(m.lsb_done), 32'd0);
    end
  endtask

  task automatic lsb_req(input bit st, input logic [31:0] a, input logic [2:0] len,
                         input logic [31:0] wd);
    m.lsb_valid = 1'b1; m.lsb_is_store = st; m.lsb_addr = a;
    m.lsb_len = len; m.lsb_wdata = wd;
  endtask

  task automatic push_exp(input bit is_if, input bit c, input logic [31:0] d);
    sb_t e;
    e.is_if = is_if; e.chk = c; e.dat = d;
    sb.push_back(e);
  endtask

  initial begin
    int lsb_off;
    int if_off;
    rst = 1'b1;
    m.rdy = 1'b1; m.rollback = 1'b0; m.if_valid = 1'b0; m.if_addr = '0;
    m.lsb_valid = 1'b0; m.lsb_is_store = 1'b0; m.lsb_addr = '0;
    m.lsb_len = 3'd1; m.lsb_wdata = '0; m.io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_wr", 32'(m.mem_wr), 32'd0);
    chk("rst_mem_a", m.mem_a, 32'd0);
    chk("rst_mem_dout", 32'(m.mem_dout), 32'd0);
    chk("rst_if_done", 32'(m.if_done), 32'd0);
    chk("rst_lsb_done", 32'(m.lsb_done), 32'd0);
    chk("rst_if_data", m.if_data, 32'd0);
    chk("rst_lsb_rdata", m.lsb_rdata, 32'd0);
    rst = 1'b0;

    addv(1, 32'h0000_0100, 3'd4, 32'h4433_2211, 32'h0,          5);
    addv(0, 32'h0000_0100, 3'd4, 32'h0,         32'h4433_2211,  6);
    addv(0, 32'h0000_0101, 3'd2, 32'h0,         32'h0000_3322,  4);
    addv(0, 32'h0000_0103, 3'd1, 32'h0,         32'h0000_0044,  3);
    addv(1, 32'h0000_0202, 3'd2, 32'h0000_775A, 32'h0,          3);
    addv(1, 32'h0000_0200, 3'd2, 32'hAABB_CCDD, 32'h0,          3);
    addv(0, 32'h0000_0200, 3'd4, 32'h0,         32'h775A_CCDD,  6);
    addv(1, 32'hFFFF_FFFF, 3'd2, 32'h0000_BEEF, 32'h0,          3);
    addv(0, 32'hFFFF_FFFF, 3'd2, 32'h0,         32'h0000_BEEF,  4);
    addv(1, 32'h0000_0000, 3'd4, 32'h1357_9BDF, 32'h0,          5);
    addv(1, 32'h0000_0010, 3'd1, 32'h0000_00A5, 32'h0,          2);
    addv(1, 32'h0000_0040, 3'd4, 32'hCAFE_F00D, 32'h0,          5);
    addv(0, 32'h0000_0010, 3'd1, 32'h0,         32'h0000_00A5,  3);
    for (int i = 0; i < vq.size(); i++) run_lsb(vq[i]);

    // Simultaneous requests: LSB load first, then the fetch.
    @(negedge clk);
    lsb_req(1'b0, 32'h10, 3'd1, 32'h0);
    m.if_valid = 1'b1; m.if_addr = 32'h0;
    push_exp(1'b0, 1'b1, 32'h0000_00A5);
    push_exp(1'b1, 1'b1, 32'h1357_9BDF);
    lsb_off = 0; if_off = 0;
    for (int off = 1; off <= 30 && if_off == 0; off++) begin
      @(negedge clk); #1;
      if (m.lsb_done && lsb_off == 0) begin
        lsb_off = off; on_done(1'b0, m.lsb_rdata); m.lsb_valid = 1'b0;
      end
      if (m.if_done) begin
        if_off = off; on_done(1'b1, m.if_data); m.if_valid = 1'b0;
      end
    end
    chk("arb_lsb_done_cycle", 32'(lsb_off), 32'd3);
    chk("arb_if_done_cycle", 32'(if_off), 32'd10);

    // Rollback during a fetch read; a new fetch is granted right after.
    @(negedge clk);
    m.if_valid = 1'b1; m.if_addr = 32'h0;
    if_off = 0;
    for (int off = 1; off <= 30 && if_off == 0; off++) begin
      @(negedge clk);
      if (off == 2) begin
        m.rollback = 1'b1; m.if_addr = 32'h40;
        push_exp(1'b1, 1'b1, 32'hCAFE_F00D);
      end
      if (off == 3) m.rollback = 1'b0;
      #1;
      if (m.if_done) begin
        if_off = off; on_done(1'b1, m.if_data); m.if_valid = 1'b0;
      end
    end
    chk("rb_if_done_cycle", 32'(if_off), 32'd9);

    // Rollback during a store: both bytes still land and done still pulses.
    @(negedge clk);
    lsb_req(1'b1, 32'h300, 3'd2, 32'h0000_6655);
    push_exp(1'b0, 1'b0, 32'h0);
    lsb_off = 0;
    for (int off = 1; off <= 30 && lsb_off == 0; off++) begin
      @(negedge clk);
      m.rollback = (off == 1);
      #1;
      if (off <= 2) chk("rb_st_mem_wr", 32'(m.mem_wr), 32'd1);
      if (m.lsb_done) begin
        lsb_off = off; on_done(1'b0, m.lsb_rdata); m.lsb_valid = 1'b0;
      end
    end
    m.rollback = 1'b0;
    chk("rb_st_done_cycle", 32'(lsb_off), 32'd3);
    addv(0, 32'h300, 3'd2, 32'h0, 32'h0000_6655, 4);
    run_lsb(vq[vq.size() - 1]);

    // IO write stalled by a full IO buffer.
    @(negedge clk);
    lsb_req(1'b1, 32'h0003_0000, 3'd1, 32'h99);
    m.io_buffer_full = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0);
    lsb_off = 0;
    for (int off = 1; off <= 30 && lsb_off == 0; off++) begin
      @(negedge clk);
      if (off == 4) m.io_buffer_full = 1'b0;
      #1;
      if (off <= 3) chk("io_stall_mem_wr", 32'(m.mem_wr), 32'd0);
      if (off == 4) begin
        chk("io_wr_mem_wr", 32'(m.mem_wr), 32'd1);
        chk("io_wr_mem_a", m.mem_a, 32'h0003_0000);
      end
      if (m.lsb_done) begin
        lsb_off = off; on_done(1'b0, m.lsb_rdata); m.lsb_valid = 1'b0;
      end
    end
    chk("io_done_cycle", 32'(lsb_off), 32'd5);
    addv(0, 32'h0003_0000, 3'd1, 32'h0, 32'h99, 3);
    run_lsb(vq[vq.size() - 1]);

    // rdy low for one cycle in the middle of a store freezes it.
    @(negedge clk);
    lsb_req(1'b1, 32'h310, 3'd2, 32'h0000_1234);
    push_exp(1'b0, 1'b0, 32'h0);
    lsb_off = 0;
    for (int off = 1; off <= 30 && lsb_off == 0; off++) begin
      @(negedge clk);
      m.rdy = (off != 1);
      #1;
      if (off == 1) chk("frz_mem_wr", 32'(m.mem_wr), 32'd0);
      if (m.lsb_done) begin
        lsb_off = off; on_done(1'b0, m.lsb_rdata); m.lsb_valid = 1'b0;
      end
    end
    m.rdy = 1'b1;
    chk("frz_done_cycle", 32'(lsb_off), 32'd4);
    addv(0, 32'h310, 3'd2, 32'h0, 32'h0000_1234, 4);
    run_lsb(vq[vq.size() - 1]);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
